// File: rtl/debug_trace_buffer.sv
// Trace capture: events from NUM_CH channels go into a circular buffer, which freezes after a trigger plus a post count.
// Capture takes 1 cycle; drain is 1 entry/cycle with rd_* combinational from storage and held stable while rd_ready is low.
module debug_trace_buffer #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     arm,
    input  logic                     clear,
    input  logic                     trig,
    input  logic [CNT_W-1:0]         post_cnt,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*TAG_W-1:0]  ch_tag,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [TS_W-1:0]          rd_ts,
    output logic [CH_W-1:0]          rd_ch,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [DATA_W-1:0]        rd_data,
    output logic [1:0]               state_o,
    output logic [CNT_W-1:0]         count_o,
    output logic                     wrapped_o,
    output logic [15:0]              drop_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int POP_W = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [CH_W-1:0]   ch;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   post_rem_q, post_rem_d;
    logic               wrapped_q, wrapped_d;
    logic [15:0]        drop_q, drop_d;
    logic [TS_W-1:0]    ts_q, ts_d;

    logic               sel_vld;
    logic [CH_W-1:0]    sel_ch;
    logic [POP_W-1:0]   vld_cnt;
    logic [16:0]        drop_sum;
    logic               wr_en;
    logic               pop;
    entry_t             wr_ent;
    entry_t             rd_ent;

    // Lowest-index valid channel wins; every other valid channel that cycle is a drop.
    always_comb begin
        sel_vld = 1'b0;
        sel_ch  = '0;
        vld_cnt = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_valid[i]) begin
                sel_vld = 1'b1;
                sel_ch  = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            vld_cnt = vld_cnt + POP_W'(ch_valid[i]);
        end
    end

    assign drop_sum = {1'b0, drop_q} + 17'(vld_cnt) - 17'd1;
    assign wr_en    = reset_n && !clear && sel_vld &&
                      (state_q == S_ARMED || state_q == S_POST);
    assign pop      = rd_valid && rd_ready;

    always_comb begin
        wr_ent      = '0;
        wr_ent.ts   = ts_q;
        wr_ent.ch   = sel_ch;
        wr_ent.tag  = ch_tag[sel_ch * TAG_W +: TAG_W];
        wr_ent.data = ch_data[sel_ch * DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (arm) state_d = S_ARMED;
                S_ARMED:  if (trig) state_d = (post_cnt == '0) ? S_FROZEN : S_POST;
                S_POST:   if (wr_en && post_rem_q == CNT_W'(1)) state_d = S_FROZEN;
                S_FROZEN: if (count_q == '0) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_valid  = (state_q == S_FROZEN) && (count_q != '0);
        rd_ent    = rd_valid ? mem_q[rd_ptr_q] : '0;
        rd_ts     = rd_ent.ts;
        rd_ch     = rd_ent.ch;
        rd_tag    = rd_ent.tag;
        rd_data   = rd_ent.data;
        state_o   = state_q;
        count_o   = count_q;
        wrapped_o = wrapped_q;
        drop_cnt  = drop_q;
    end

    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_rem_d = post_rem_q;
        wrapped_d  = wrapped_q;
        drop_d     = drop_q;
        if (clear) begin
            count_d = '0;
        end else begin
            if (state_q == S_IDLE && arm) begin
                wr_ptr_d  = '0;
                count_d   = '0;
                wrapped_d = 1'b0;
                drop_d    = '0;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (count_q < CNT_W'(DEPTH)) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    wrapped_d = 1'b1;
                end
                if (vld_cnt > POP_W'(1)) begin
                    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                end
            end
            if (state_q == S_ARMED && trig && post_cnt != '0) begin
                post_rem_d = (post_cnt > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : post_cnt;
            end else if (state_q == S_POST && wr_en) begin
                post_rem_d = post_rem_q - CNT_W'(1);
            end
            // A full buffer gives count mod DEPTH == 0, so the oldest entry sits at wr_ptr.
            if (state_q != S_FROZEN && state_d == S_FROZEN) begin
                rd_ptr_d = wr_ptr_d - count_d[PTR_W-1:0];
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                count_d  = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_rem_q <= '0;
            wrapped_q  <= 1'b0;
            drop_q     <= '0;
            ts_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_rem_q <= post_rem_d;
            wrapped_q  <= wrapped_d;
            drop_q     <= drop_d;
            ts_q       <= ts_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_ent;
        end
    end

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Randomized and directed bench for debug_trace_buffer with a queue-based reference model and a pop scoreboard.
module tb_debug_trace_buffer;
    logic         clk;
    logic         reset_n;
    logic         arm, clear, trig;
    logic [4:0]   post_cnt;
    logic [3:0]   ch_valid;
    logic [11:0]  ch_tag;
    logic [127:0] ch_data;
    logic         rd_valid, rd_ready;
    logic [15:0]  rd_ts;
    logic [1:0]   rd_ch;
    logic [2:0]   rd_tag;
    logic [31:0]  rd_data;
    logic [1:0]   state_o;
    logic [4:0]   count_o;
    logic         wrapped_o;
    logic [15:0]  drop_cnt;

    debug_trace_buffer #(
        .NUM_CH(4), .DATA_W(32), .TAG_W(3), .DEPTH(16), .TS_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .clear(clear), .trig(trig),
        .post_cnt(post_cnt), .ch_valid(ch_valid), .ch_tag(ch_tag), .ch_data(ch_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ts(rd_ts), .rd_ch(rd_ch),
        .rd_tag(rd_tag), .rd_data(rd_data), .state_o(state_o), .count_o(count_o),
        .wrapped_o(wrapped_o), .drop_cnt(drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [15:0] ts;
        logic [1:0]  ch;
        logic [2:0]  tag;
        logic [31:0] data;
    } ent_t;

    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: captured entries as a queue; frozen contents copied to the scoreboard.
    ent_t m_q[$];
    ent_t exp_q[$];
    int   m_state = 0;
    int   m_count = 0;
    int   m_post  = 0;
    int   m_drop  = 0;
    int   m_ts    = 0;
    bit   m_wrapped = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int   nv;
        int   c;
        bit   freeze;
        ent_t e;
        if (!reset_n) begin
            m_state = 0; m_count = 0; m_post = 0; m_drop = 0; m_ts = 0; m_wrapped = 1'b0;
            m_q.delete();
            exp_q.delete();
            return;
        end
        nv = $countones(ch_valid);
        freeze = 1'b0;
        if (clear) begin
            m_state = 0;
            m_count = 0;
            exp_q.delete();
        end else begin
            case (m_state)
                0: if (arm) begin
                    chk("drain_complete", 64'(exp_q.size()), 64'd0);
                    m_state = 1; m_count = 0; m_drop = 0; m_wrapped = 1'b0;
                    m_q.delete();
                end
                1, 2: begin
                    if (nv > 0) begin
                        c = 0;
                        while (!ch_valid[c]) c++;
                        e.ts   = 16'(m_ts);
                        e.ch   = 2'(c);
                        e.tag  = ch_tag[c*3 +: 3];
                        e.data = ch_data[c*32 +: 32];
                        m_q.push_back(e);
                        if (m_q.size() > 16) begin
                            void'(m_q.pop_front());
                            m_wrapped = 1'b1;
                        end
                        m_count = m_q.size();
                        m_drop  = (m_drop + nv - 1 > 65535) ? 65535 : m_drop + nv - 1;
                    end
                    if (m_state == 1 && trig) begin
                        if (post_cnt == 0) freeze = 1'b1;
                        else begin
                            m_post  = (post_cnt > 16) ? 16 : int'(post_cnt);
                            m_state = 2;
                        end
                    end else if (m_state == 2 && nv > 0) begin
                        m_post--;
                        if (m_post == 0) freeze = 1'b1;
                    end
                    if (freeze) begin
                        m_state = 3;
                        foreach (m_q[i]) exp_q.push_back(m_q[i]);
                    end
                end
                default: begin
                    if (m_count == 0) m_state = 0;
                    else if (rd_ready) m_count--;
                end
            endcase
        end
        m_ts = (m_ts + 1) & 16'hFFFF;
    endtask

    task automatic check_outputs();
        chk("state", 64'(state_o), 64'(m_state));
        chk("count", 64'(count_o), 64'(m_count));
        chk("wrapped", 64'(wrapped_o), 64'(m_wrapped));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("rd_valid", 64'(rd_valid), 64'(m_state == 3 && m_count != 0));
        if (m_count == 0) chk("rd_zero", 64'({rd_ts, rd_ch, rd_tag, rd_data}), 64'd0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit a, input bit c, input bit t, input int p,
                         input logic [3:0] v, input bit rr);
        arm = a; clear = c; trig = t; post_cnt = 5'(p); ch_valid = v; rd_ready = rr;
        ch_tag  = 12'($urandom);
        ch_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Scoreboard: every accepted pop must match the oldest outstanding expected entry.
    always @(negedge clk) begin
        if (reset_n && !clear && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got entry 0x%0h expected none at %0t",
                         {rd_ts, rd_ch, rd_tag, rd_data}, $time);
            end else begin
                chk("pop_entry", 64'({rd_ts, rd_ch, rd_tag, rd_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prev_ts;
        int k;
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 4'b0000, 0);
        tick();
        tick();
        reset_n = 1'b1;

        // Reset in the middle of POST with nine entries held.
        drive(1, 0, 0, 0, 4'b0000, 0); tick();
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, i == 4, 10, 4'b0001, 0);
            tick();
        end
        chk("t1_post_state", 64'(state_o), 64'd2);
        chk("t1_post_count", 64'(count_o), 64'd9);
        reset_n = 1'b0; drive(0, 0, 0, 0, 4'b0000, 0); tick();
        reset_n = 1'b1; tick();
        chk("t1_state", 64'(state_o), 64'd0);
        chk("t1_count", 64'(count_o), 64'd0);
        chk("t1_rd_valid", 64'(rd_valid), 64'd0);

        // Five events on channel 2, trigger on the last with no post count.
        drive(1, 0, 0, 0, 4'b0000, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, i == 4, 0, 4'b0100, 0);
            ch_data[64 +: 32] = 32'h10 + 32'(i);
            tick();
        end
        chk("t2_state", 64'(state_o), 64'd3);
        chk("t2_count", 64'(count_o), 64'd5);
        drive(0, 0, 0, 0, 4'b0000, 1);
        prev_ts = 16'd0;
        k = 0;
        for (int n = 0; n < 40 && state_o != 2'd0; n++) begin
            if (rd_valid) begin
                chk("t2_data", 64'(rd_data), 64'(32'h10 + 32'(k)));
                chk("t2_ch", 64'(rd_ch), 64'd2);
                if (k > 0) chk("t2_ts_incr", 64'(rd_ts > prev_ts), 64'd1);
                prev_ts = rd_ts;
                k++;
            end
            tick();
        end
        chk("t2_drained", 64'(k), 64'd5);
        chk("t2_idle", 64'(state_o), 64'd0);

        // Twenty events overflow the sixteen-entry buffer.
        drive(1, 0, 0, 0, 4'b0000, 0); tick();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, i == 19, 0, 4'b0001, 0);
            ch_data[31:0] = 32'(i);
            tick();
        end
        chk("t3_count", 64'(count_o), 64'd16);
        chk("t3_wrapped", 64'(wrapped_o), 64'd1);
        drive(0, 0, 0, 0, 4'b0000, 1);
        k = 0;
        for (int n = 0; n < 40 && state_o != 2'd0; n++) begin
            if (rd_valid) begin
                chk("t3_data", 64'(rd_data), 64'(4 + k));
                k++;
            end
            tick();
        end
        chk("t3_drained", 64'(k), 64'd16);
        chk("t3_idle", 64'(state_o), 64'd0);

        // Contention: lowest channel wins, the rest are dropped.
        drive(1, 0, 0, 0, 4'b0000, 0); tick();
        drive(0, 0, 0, 0, 4'b1110, 0); tick();
        chk("t4_drop2", 64'(drop_cnt), 64'd2);
        drive(0, 0, 0, 0, 4'b1111, 0); tick();
        chk("t4_drop5", 64'(drop_cnt), 64'd5);
        drive(0, 0, 1, 0, 4'b0000, 0); tick();
        chk("t4_first_ch", 64'(rd_ch), 64'd1);
        drive(0, 0, 0, 0, 4'b0000, 1); tick();
        chk("t4_second_ch", 64'(rd_ch), 64'd0);
        for (int n = 0; n < 10 && state_o != 2'd0; n++) tick();
        chk("t4_idle", 64'(state_o), 64'd0);

        // Post-trigger count of three: A (trigger), B, C, D captured; E is not.
        drive(1, 0, 0, 0, 4'b0000, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, i == 0, 3, 4'b0010, 0);
            ch_data[32 +: 32] = 32'hA + 32'(i);
            tick();
            if (i == 3) chk("t5_frozen_after_d", 64'(state_o), 64'd3);
        end
        chk("t5_count", 64'(count_o), 64'd4);
        chk("t5_oldest", 64'(rd_data), 64'hA);

        // Pop one with rd_ready toggling, then clear beats arm.
        drive(0, 0, 0, 0, 4'b0000, 0); tick();
        chk("t6_stall_hold", 64'(rd_data), 64'hA);
        drive(0, 0, 0, 0, 4'b0000, 1); tick();
        drive(0, 0, 0, 0, 4'b0000, 0); tick();
        chk("t6_count", 64'(count_o), 64'd3);
        chk("t6_next", 64'(rd_data), 64'hB);
        drive(1, 1, 0, 0, 4'b0000, 1); tick();
        chk("t6_clear_state", 64'(state_o), 64'd0);
        chk("t6_clear_count", 64'(count_o), 64'd0);
        chk("t6_clear_valid", 64'(rd_valid), 64'd0);
        drive(1, 0, 0, 0, 4'b0000, 0); tick();
        chk("t6_rearm", 64'(state_o), 64'd1);
        drive(0, 1, 0, 0, 4'b0000, 0); tick();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            drive($urandom_range(0, 7) == 0, r >= 3 && r < 10, $urandom_range(0, 15) == 0,
                  int'($urandom_range(0, 31)), 4'($urandom), $urandom_range(0, 3) != 0);
            reset_n = (r < 3) ? 1'b0 : 1'b1;
            tick();
        end
        reset_n = 1'b1;
        drive(0, 1, 0, 0, 4'b0000, 0); tick();
        drive(0, 0, 0, 0, 4'b0000, 0); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
